// File: rtl/ami_channel_arbiter.sv
// Round-robin arbiter/sequencer sharing one 256-bit AMI command/response path among NUM_REQ requesters.
// Optional stall timeout: define AMI_ARB_TIMEOUT_EN to complete a hung AMI access with status 3'b111.
module ami_channel_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*256-1:0] req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [255:0]           rsp_data,
    output logic [2:0]             rsp_status,
    output logic                   busy,
    output logic [255:0]           fsm_ami,
    output logic                   ami_valid,
    input  logic [2:0]             ami_ack,
    input  logic [255:0]           ami_out
);

    localparam int unsigned N  = NUM_REQ;
    localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("ami_channel_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic [PW-1:0]  sel, sel_n;
    logic [PW-1:0]  win, rr_pos;
    logic           found;
    logic [NUM_REQ-1:0] grant_n;
    logic [255:0]   fsm_ami_n, rsp_data_n;
    logic [2:0]     rsp_status_n;

`ifdef AMI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
    logic [CW-1:0]  cnt, cnt_n;
`endif

    // Walk the request vector starting one past the last served requester, wrapping.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        rr_pos = (ptr == LAST) ? '0 : ptr + 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[rr_pos]) begin
                found = 1'b1;
                win   = rr_pos;
            end
            rr_pos = (rr_pos == LAST) ? '0 : rr_pos + 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        sel_n        = sel;
        grant_n      = grant;
        fsm_ami_n    = fsm_ami;
        rsp_data_n   = rsp_data;
        rsp_status_n = rsp_status;
`ifdef AMI_ARB_TIMEOUT_EN
        cnt_n        = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = WAIT;
                    sel_n   = win;
`ifdef AMI_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                    for (int unsigned j = 0; j < N; j++) begin
                        grant_n[j] = (win == PW'(j));
                        if (win == PW'(j)) fsm_ami_n = req_data[256*j +: 256];
                    end
                end
            end
            WAIT: begin
                if (ami_ack != 3'b000) begin
                    rsp_data_n   = ami_out;
                    rsp_status_n = ami_ack;
                    state_n      = RESP;
                end
`ifdef AMI_ARB_TIMEOUT_EN
                else if (cnt == TMAX) begin
                    rsp_data_n   = '0;
                    rsp_status_n = 3'b111;
                    state_n      = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_n   = sel;
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= LAST;
            sel        <= '0;
            grant      <= '0;
            fsm_ami    <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
`ifdef AMI_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            sel        <= sel_n;
            grant      <= grant_n;
            fsm_ami    <= fsm_ami_n;
            rsp_data   <= rsp_data_n;
            rsp_status <= rsp_status_n;
`ifdef AMI_ARB_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

    // Strobes decode straight from the state register so reset clears them without a clock.
    assign ami_valid = (state == WAIT);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP) ? grant : '0;

endmodule

// File: tb/tb_ami_channel_arbiter.sv
// Self-checking bench for ami_channel_arbiter: transaction-level model plus directed and random traffic.
// Timeout scenarios run only when AMI_ARB_TIMEOUT_EN is defined.
module tb_ami_channel_arbiter;

    localparam int N = 3;
    localparam int T = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*256-1:0]   req_data;
    logic [N-1:0]       grant, rsp_valid;
    logic [255:0]       rsp_data, fsm_ami, ami_out;
    logic [2:0]         rsp_status, ami_ack;
    logic               busy, ami_valid;

    always #5 clk = ~clk;

    ami_channel_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .busy(busy), .fsm_ami(fsm_ami),
        .ami_valid(ami_valid), .ami_ack(ami_ack), .ami_out(ami_out)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], $urandom};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: who owns the channel, whether it awaits AMI or is reporting back.
    int           m_owner;
    bit           m_active, m_resp;
    int           m_last, m_cnt;
    logic [255:0] m_cmd, m_rdata;
    logic [2:0]   m_rstat;

    always @(posedge clk or posedge rst) begin
        int c;
        if (rst) begin
            m_owner = -1; m_active = 0; m_resp = 0; m_last = N - 1; m_cnt = 0;
            m_cmd = '0; m_rdata = '0; m_rstat = '0;
        end else if (m_resp) begin
            m_last  = m_owner;
            m_owner = -1;
            m_resp  = 0;
        end else if (m_active) begin
            if (ami_ack != 0) begin
                m_rdata = ami_out; m_rstat = ami_ack; m_active = 0; m_resp = 1;
            end
`ifdef AMI_ARB_TIMEOUT_EN
            else if (m_cnt == T - 1) begin
                m_rdata = '0; m_rstat = 3'b111; m_active = 0; m_resp = 1;
            end else begin
                m_cnt++;
            end
`endif
        end else if (req != 0) begin
            for (int i = 0; i < N; i++) begin
                c = (m_last + 1 + i) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_cmd    = req_data[m_owner*256 +: 256];
            m_active = 1;
            m_cnt    = 0;
        end
    end

    logic [N-1:0] eg;
    always @(negedge clk) begin
        if (cmp_en) begin
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("grant", grant, eg);
            chk("rsp_valid", rsp_valid, m_resp ? eg : '0);
            chk("ami_valid", ami_valid, m_active);
            chk("busy", busy, m_owner >= 0);
            chk("fsm_ami", fsm_ami, m_cmd);
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_status", rsp_status, m_rstat);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req = '0;
        for (int k = 0; k < 20; k++) begin
            ami_ack = ami_valid ? 3'b001 : 3'b000;
            tick();
        end
        ami_ack = '0;
        tick();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1);
    end

    int           got[$];
    int           exp_ord[6] = '{0, 1, 2, 0, 1, 2};
    int           n;
    logic [N-1:0] rv_last;

    initial begin
        rst = 1'b1; req = '0; req_data = '0; ami_ack = '0; ami_out = '0;
        #12;
        chk("reset_grant", grant, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ami_valid", ami_valid, 1'b0);
        chk("reset_fsm_ami", fsm_ami, '0);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single transaction from requester 0.
        req_data[255:0] = {32{8'hA5}};
        req = 3'b001;
        tick();
        chk("t1_ami_valid", ami_valid, 1'b1);
        chk("t1_grant", grant, 3'b001);
        tick();
        tick();
        ami_ack = 3'b001; ami_out = 256'h1234;
        tick();
        ami_ack = '0; req = '0;
        chk("t1_rsp_valid", rsp_valid, 3'b001);
        chk("t1_rsp_data", rsp_data, 256'h1234);
        chk("t1_rsp_status", rsp_status, 3'b001);
        chk("t1_fsm_ami", fsm_ami, {32{8'hA5}});
        tick();
        chk("t1_rsp_pulse_end", rsp_valid, 3'b000);

        // Ack while idle is ignored.
        ami_ack = 3'b010; ami_out = rand256();
        repeat (3) tick();
        chk("idle_ack_busy", busy, 1'b0);
        chk("idle_ack_rsp_data", rsp_data, 256'h1234);
        chk("idle_ack_status", rsp_status, 3'b001);
        ami_ack = '0;

        // Requester 1 changes its word after grant.
        req_data[511:256] = {8{32'hDEADBEEF}};
        req = 3'b010;
        tick();
        chk("t3_grant", grant, 3'b010);
        req_data[511:256] = {8{32'h01234567}};
        repeat (3) tick();
        chk("t3_fsm_ami_held", fsm_ami, {8{32'hDEADBEEF}});
        ami_ack = 3'b100; ami_out = 256'hBEEF;
        tick();
        ami_ack = '0;
        chk("t3_rsp_valid", rsp_valid, 3'b010);
        chk("t3_status", rsp_status, 3'b100);
        req = '0;
        tick();

        // All requesters held, immediate acks: strict rotation.
        do_reset();
        req = 3'b111;
        got.delete();
        for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
            ami_ack = ami_valid ? 3'b001 : 3'b000;
            ami_out = rand256();
            tick();
            if (rsp_valid != 0) begin
                chk("t2_onehot", $onehot(rsp_valid), 1'b1);
                for (int j = 0; j < N; j++) if (rsp_valid[j]) got.push_back(j);
            end
        end
        chk("t2_count", got.size(), 6);
        for (int k = 0; k < got.size() && k < 6; k++) chk("t2_order", got[k], exp_ord[k]);
        drain();

        // Reset while waiting on AMI.
        do_reset();
        req_data[767:512] = rand256();
        req = 3'b100;
        tick();
        chk("rst_pre_ami_valid", ami_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ami_valid", ami_valid, 1'b0);
        chk("rst_async_grant", grant, 3'b000);
        chk("rst_async_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("rst_no_rsp", rsp_valid, 3'b000);
        rst = 1'b0;
        req = 3'b101;
        tick();
        chk("rst_prio0", grant, 3'b001);
        drain();

`ifdef AMI_ARB_TIMEOUT_EN
        do_reset();
        req = 3'b001;
        tick();
        n = 1;
        while (rsp_valid == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 17);
        chk("to_status", rsp_status, 3'b111);
        chk("to_data", rsp_data, '0);
        req = 3'b010;
        tick();
        tick();
        ami_ack = 3'b011; ami_out = 256'h55;
        tick();
        ami_ack = '0; req = '0;
        chk("to_next_status", rsp_status, 3'b011);
        tick();
        req = 3'b001;
        tick();
        repeat (15) tick();
        ami_ack = 3'b101; ami_out = 256'h77;
        tick();
        ami_ack = '0; req = '0;
        chk("to_late_ack_valid", rsp_valid, 3'b001);
        chk("to_late_ack_status", rsp_status, 3'b101);
        tick();
`endif

        // Random traffic against the model.
        do_reset();
        rv_last = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (rv_last[i] && $urandom_range(3) != 0) req[i] = 1'b0;
                    else if (rv_last[i]) req_data[i*256 +: 256] = rand256();
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*256 +: 256] = rand256();
                end
            end
            if (ami_valid) ami_ack = ($urandom_range(2) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
            else           ami_ack = ($urandom_range(7) == 0) ? 3'b010 : 3'b000;
            ami_out = rand256();
            tick();
            rv_last = rsp_valid;
        end
        drain();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
